dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer for the single-port synchronous data memory. It sits between the MEM stage of the MIPS pipeline and the debug unit. It shares the memory between the two requesters, steers bytes and halfwords to the correct lanes, and extends load data to 32 bits. It also stalls the pipeline for the extra cycle that a synchronous-read load needs.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address width of the data memory.
- WAIT_LIMIT, 4: consecutive cycles a blocked debug request may wait before it is forced through.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM-stage access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  access size: `SIZE_BYTE` = 00, `SIZE_HALF` = 01, `SIZE_WORD` = 10.
- cpu_unsigned  in  1  load zero-extends (LBU, LHU, LWU).
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data, in the low bits.
- cpu_rdata  out  32  extended load data.
- cpu_stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- cpu_misaligned  out  1  one-cycle pulse on an illegal alignment.
- dbg_req  in  1  debug request, held until granted.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_WIDTH  debug word address.
- dbg_wdata  in  32  debug write word.
- dbg_gnt  out  1  one-cycle pulse when the debug request is accepted.
- dbg_rdata  out  32  debug read word.
- dbg_valid  out  1  pulse one cycle after a granted debug read.
- mem_en  out  1  memory enable.
- mem_we  out  4  byte write enables.
- mem_addr  out  ADDR_WIDTH  word address, taken from cpu_addr[ADDR_WIDTH+1:2].
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.

## Operation
States: IDLE, CPU_RD, DBG_RD.

Arbitration in IDLE:
- The CPU wins over debug.
- The exception is when wait_cnt == WAIT_LIMIT. In that case debug wins, cpu_stall = 1 for that cycle, and wait_cnt is cleared.
- wait_cnt increments on each cycle where dbg_req is blocked, and saturates at WAIT_LIMIT. It clears on dbg_gnt.

CPU store:
- Completes in the cycle it is accepted, with no stall.
- mem_we comes from size and addr[1:0], little-endian: byte lane = addr[1:0]; half at addr[1] uses lanes 1:0 or 3:2; word uses 1111.
- mem_wdata carries the byte replicated ×4 or the half replicated ×2.

CPU load:
- Cycle 0: mem_en = 1 and cpu_stall = 1, then go to CPU_RD.
- Cycle 1 (CPU_RD): select the lane from the registered addr[1:0]. Sign-extend unless cpu_unsigned is set. Drive the result on cpu_rdata with cpu_stall = 0, then return to IDLE.
- LW and LWU return the word unchanged.
- cpu_req stays asserted during CPU_RD because of the stall. It is not re-accepted.

Debug accesses:
- A debug write completes in one cycle with mem_we = 1111.
- A debug read goes to DBG_RD. dbg_valid is asserted with the data on the next cycle.
- A CPU request arriving while in DBG_RD is stalled for that cycle.

Misaligned access:
- Condition: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
- Response: cpu_misaligned pulses, with no memory access, no stall and cpu_rdata = 0.
- cpu_size = 11 is treated as misaligned.

## Timing
Reset values:
- state = IDLE, wait_cnt = 0.
- All outputs are 0, including cpu_rdata and dbg_rdata.

Latency:
- Load: 1 stall cycle.
- Store: 0 stall cycles.
- Debug read: dbg_valid 1 cycle after dbg_gnt.

Reset asserted during CPU_RD or DBG_RD:
- The pending read is dropped and no dbg_valid or data is produced.
- The FSM resumes from IDLE after reset is released.

Other rules:
- mem_en and mem_we are never asserted for both requesters in the same cycle.
- cpu_rdata and dbg_rdata hold their last value until the next read completes.

## Structure
- mips_pkg.vh gains `SIZE_BYTE`, `SIZE_HALF` and `SIZE_WORD`, plus the state encodings ARB_IDLE, ARB_CPU_RD and ARB_DBG_RD.
- Sub-module load_store_align is purely combinational. It produces store lane replication and byte enables, and load lane select plus sign/zero extension.
- The FSM, wait counter and registered addr[1:0], size and unsigned flag stay in dmem_arbiter.

## Test plan
- SB 0xFF to 0x10, then LB and LBU from 0x10 → 0xFFFFFFFF and 0x000000FF. Each load shows exactly one cpu_stall cycle.
- SH 0xCFC7 to 0x22, then LH and LHU → 0xFFFFCFC7 and 0x0000CFC7. mem_we = 1100 on the store.
- SW 0x00005678 to 0x30, then LW and LWU → 0x00005678 for both. Store to 0x31 → cpu_misaligned pulse, mem_we = 0, memory unchanged.
- Stream CPU stores every cycle while dbg_req reads 0x0C. Required: dbg_gnt arrives after exactly WAIT_LIMIT = 4 blocked cycles, cpu_stall = 1 in that cycle, and dbg_valid follows with 0x00005678.
- CPU load and dbg_req in the same cycle → CPU granted first and wait_cnt = 1. Debug is granted in the cycle after CPU_RD.
- Assert reset during CPU_RD → all outputs 0 and state IDLE. A subsequent LW returns correct data.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared constants for the data-memory arbiter:
//   - access size encodings used by the MEM stage (byte / half / word)
//   - arbiter FSM state encodings
//   - is_misaligned() helper that flags an illegal size/alignment combination
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'b00;
    localparam size_t SIZE_HALF = 2'b01;
    localparam size_t SIZE_WORD = 2'b10;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_CPU_RD = 2'd1;
    localparam logic [1:0] ARB_DBG_RD = 2'd2;

    // The reserved size code 11 has no legal alignment, so it is reported
    // the same way as a badly aligned half or word.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
// Purely combinational lane steering for the data memory.
// Store side: replicates a byte (x4) or a half (x2) across the word and
// produces little-endian byte enables from size and addr[1:0].
// Load side: selects the addressed byte/half from the memory word and
// sign- or zero-extends it to 32 bits; words pass through unchanged.
// Ports:
//   st_size, st_addr_lo, st_data  store request (size, addr[1:0], data in low bits)
//   st_be, st_lanes               byte enables and lane-replicated write data
//   ld_size, ld_addr_lo, ld_unsigned, ld_word   registered load info + memory word
//   ld_data                       extended load result
// -----------------------------------------------------------------------------
module load_store_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be    = 4'b0000;
        st_lanes = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            SIZE_WORD: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_lanes = st_data;
            end
        endcase
    end

    always_comb begin
        byte_shifted = ld_word >> {ld_addr_lo, 3'b000};
        byte_sel     = byte_shifted[7:0];
        half_sel     = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SIZE_BYTE: ld_data = ld_unsigned ? {24'h000000, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: ld_data = ld_unsigned ? {16'h0000, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port synchronous data memory between the MEM stage and
// the debug unit. The CPU normally wins; a debug request that has been
// blocked WAIT_LIMIT consecutive cycles is forced through and stalls the CPU
// for that cycle. Loads take one extra stall cycle because memory read data
// arrives the cycle after mem_en.
// Ports:
//   clk, reset                     clock, async active-high reset
//   cpu_req/we/size/unsigned/addr/wdata   MEM-stage access
//   cpu_rdata, cpu_stall, cpu_misaligned  load result, pipeline freeze, alignment error
//   dbg_req/we/addr/wdata          debug word access (held until dbg_gnt)
//   dbg_gnt, dbg_rdata, dbg_valid  debug accept pulse, read data, read-valid pulse
//   mem_en/we/addr/wdata, mem_rdata  synchronous memory port
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_misaligned,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_gnt,
    output logic [31:0]           dbg_rdata,
    output logic                  dbg_valid,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int              CW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]   WAIT_MAX = CW'(WAIT_LIMIT);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    rd_addr_lo;
    logic [1:0]    rd_size;
    logic          rd_unsigned;
    logic [31:0]   cpu_rdata_q;
    logic [31:0]   dbg_rdata_q;

    logic          in_idle;
    logic          dbg_force;
    logic          cpu_take;
    logic          cpu_bad;
    logic          cpu_ok;
    logic          dbg_take;
    logic [3:0]    st_be;
    logic [31:0]   st_lanes;
    logic [31:0]   ld_data;

    // Only the word-address slice of the byte address reaches the memory.
    logic          addr_unused;
    assign addr_unused = ^cpu_addr[31:ADDR_WIDTH+2];

    load_store_align u_align (
        .st_size     (cpu_size),
        .st_addr_lo  (cpu_addr[1:0]),
        .st_data     (cpu_wdata),
        .st_be       (st_be),
        .st_lanes    (st_lanes),
        .ld_size     (rd_size),
        .ld_addr_lo  (rd_addr_lo),
        .ld_unsigned (rd_unsigned),
        .ld_word     (mem_rdata),
        .ld_data     (ld_data)
    );

    // Requests are only accepted in IDLE. Gating with reset keeps every
    // output at zero while reset is held, even with requests present.
    always_comb begin
        in_idle   = (state == ARB_IDLE);
        dbg_force = dbg_req && (wait_cnt == WAIT_MAX);
        cpu_take  = !reset && in_idle && cpu_req && !dbg_force;
        cpu_bad   = cpu_take && is_misaligned(cpu_size, cpu_addr[1:0]);
        cpu_ok    = cpu_take && !cpu_bad;
        dbg_take  = !reset && in_idle && dbg_req && !cpu_take;
    end

    // A misaligned CPU access still owns the cycle (debug stays blocked) but
    // never touches the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        cpu_stall = 1'b0;
        dbg_gnt   = 1'b0;
        if (cpu_ok) begin
            mem_en   = 1'b1;
            mem_addr = cpu_addr[ADDR_WIDTH+1:2];
            if (cpu_we) begin
                mem_we    = st_be;
                mem_wdata = st_lanes;
            end else begin
                cpu_stall = 1'b1;
            end
        end else if (dbg_take) begin
            mem_en    = 1'b1;
            mem_addr  = dbg_addr;
            dbg_gnt   = 1'b1;
            cpu_stall = cpu_req;
            if (dbg_we) begin
                mem_we    = 4'b1111;
                mem_wdata = dbg_wdata;
            end
        end else if (state == ARB_DBG_RD) begin
            cpu_stall = cpu_req;
        end
    end

    // Read results are live from memory in the completing cycle and then
    // held in the shadow registers until the next read of that requester.
    always_comb begin
        cpu_misaligned = cpu_bad;
        dbg_valid      = (state == ARB_DBG_RD);
        dbg_rdata      = (state == ARB_DBG_RD) ? mem_rdata : dbg_rdata_q;
        if (state == ARB_CPU_RD) begin
            cpu_rdata = ld_data;
        end else if (cpu_bad) begin
            cpu_rdata = 32'h0;
        end else begin
            cpu_rdata = cpu_rdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            rd_addr_lo  <= 2'b00;
            rd_size     <= SIZE_BYTE;
            rd_unsigned <= 1'b0;
            cpu_rdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (cpu_ok && !cpu_we) begin
                        state <= ARB_CPU_RD;
                    end else if (dbg_take && !dbg_we) begin
                        state <= ARB_DBG_RD;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
            if (cpu_ok && !cpu_we) begin
                rd_addr_lo  <= cpu_addr[1:0];
                rd_size     <= cpu_size;
                rd_unsigned <= cpu_unsigned;
            end
            if (state == ARB_CPU_RD) begin
                cpu_rdata_q <= ld_data;
            end
            if (state == ARB_DBG_RD) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    // Blocked debug cycles are counted in every state, so a debug request
    // that arrives with a load waits through CPU_RD as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (dbg_gnt) begin
            wait_cnt <= '0;
        end else if (dbg_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural synchronous memory and
// scoreboard queues holding the expected CPU and debug read data.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int ADDR_WIDTH = 8;
    localparam int WAIT_LIMIT = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [1:0]            cpu_size;
    logic                  cpu_unsigned;
    logic [31:0]           cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [31:0]           cpu_rdata;
    logic                  cpu_stall;
    logic                  cpu_misaligned;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [31:0]           dbg_wdata;
    logic                  dbg_gnt;
    logic [31:0]           dbg_rdata;
    logic                  dbg_valid;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata = 32'h0;

    logic [31:0] mem_model [0:255];
    logic [31:0] cpu_exp_q [$];
    logic [31:0] dbg_exp_q [$];

    int compared   = 0;
    int mismatched = 0;

    dmem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_size       (cpu_size),
        .cpu_unsigned   (cpu_unsigned),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .cpu_misaligned (cpu_misaligned),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_gnt        (dbg_gnt),
        .dbg_rdata      (dbg_rdata),
        .dbg_valid      (dbg_valid),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem_model[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic req, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic dreq, input logic dwe, input logic [7:0] daddr,
                                 input logic [31:0] dwdata);
        cpu_req      = req;
        cpu_we       = we;
        cpu_size     = size;
        cpu_unsigned = uns;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        dbg_req      = dreq;
        dbg_we       = dwe;
        dbg_addr     = daddr;
        dbg_wdata    = dwdata;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic popCpu(input string tag);
        if (cpu_exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected <empty scoreboard>", tag, cpu_rdata);
        end else begin
            checkOutput(tag, cpu_rdata, cpu_exp_q.pop_front());
        end
    endtask

    task automatic popDbg(input string tag);
        if (dbg_exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected <empty scoreboard>", tag, dbg_rdata);
        end else begin
            checkOutput(tag, dbg_rdata, dbg_exp_q.pop_front());
        end
    endtask

    task automatic toSample();
        @(negedge clk);
    endtask

    task automatic toNext();
        @(posedge clk);
        #1;
    endtask

    task automatic doStore(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_we);
        applyStimulus(1'b1, 1'b1, size, 1'b0, addr, data, 1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
        checkOutput({tag, " stall"}, 32'(cpu_stall), 32'd0);
        checkOutput({tag, " misaligned"}, 32'(cpu_misaligned), 32'd0);
        toNext();
        clearInputs();
    endtask

    task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, size, uns, addr, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        cpu_exp_q.push_back(expected);
        toSample();
        checkOutput({tag, " stall c0"}, 32'(cpu_stall), 32'd1);
        checkOutput({tag, " mem_en c0"}, 32'(mem_en), 32'd1);
        toNext();
        toSample();
        checkOutput({tag, " stall c1"}, 32'(cpu_stall), 32'd0);
        popCpu({tag, " rdata"});
        toNext();
        clearInputs();
        toSample();
        checkOutput({tag, " rdata hold"}, cpu_rdata, expected);
        toNext();
    endtask

    initial begin
        int  blocked;
        int  idx;
        bit  granted;

        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0);
        toNext();
        toSample();
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset dbg_gnt", 32'(dbg_gnt), 32'd0);
        checkOutput("reset cpu_rdata", cpu_rdata, 32'h0);
        checkOutput("reset dbg_rdata", dbg_rdata, 32'h0);
        checkOutput("reset dbg_valid", 32'(dbg_valid), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        toNext();
        clearInputs();
        reset = 1'b0;
        toNext();

        $display("[TB] byte store / loads");
        doStore("SB 0x10", SIZE_BYTE, 32'h10, 32'h000000FF, 4'b0001);
        doLoad("LB 0x10", SIZE_BYTE, 1'b0, 32'h10, 32'hFFFFFFFF);
        doLoad("LBU 0x10", SIZE_BYTE, 1'b1, 32'h10, 32'h000000FF);

        $display("[TB] half store / loads");
        doStore("SH 0x22", SIZE_HALF, 32'h22, 32'h0000CFC7, 4'b1100);
        doLoad("LH 0x22", SIZE_HALF, 1'b0, 32'h22, 32'hFFFFCFC7);
        doLoad("LHU 0x22", SIZE_HALF, 1'b1, 32'h22, 32'h0000CFC7);

        $display("[TB] word store / loads");
        doStore("SW 0x30", SIZE_WORD, 32'h30, 32'h00005678, 4'b1111);
        doLoad("LW 0x30", SIZE_WORD, 1'b0, 32'h30, 32'h00005678);
        doLoad("LWU 0x30", SIZE_WORD, 1'b1, 32'h30, 32'h00005678);

        $display("[TB] misaligned accesses");
        applyStimulus(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h31, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput("SW 0x31 misaligned", 32'(cpu_misaligned), 32'd1);
        checkOutput("SW 0x31 mem_we", 32'(mem_we), 32'd0);
        checkOutput("SW 0x31 mem_en", 32'(mem_en), 32'd0);
        checkOutput("SW 0x31 stall", 32'(cpu_stall), 32'd0);
        checkOutput("SW 0x31 rdata", cpu_rdata, 32'h0);
        toNext();
        clearInputs();
        toSample();
        checkOutput("SW 0x31 pulse end", 32'(cpu_misaligned), 32'd0);
        checkOutput("SW 0x31 memory unchanged", mem_model[12], 32'h00005678);
        toNext();
        applyStimulus(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h23, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput("LH 0x23 misaligned", 32'(cpu_misaligned), 32'd1);
        checkOutput("LH 0x23 stall", 32'(cpu_stall), 32'd0);
        toNext();
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput("size 11 misaligned", 32'(cpu_misaligned), 32'd1);
        checkOutput("size 11 mem_en", 32'(mem_en), 32'd0);
        toNext();
        clearInputs();
        toNext();

        $display("[TB] debug starvation limit");
        blocked = 0;
        idx     = 0;
        granted = 1'b0;
        for (int i = 0; i < 10 && !granted; i++) begin
            applyStimulus(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40 + 32'(4 * idx), 32'(idx),
                          1'b1, 1'b0, 8'h0C, 32'h0);
            toSample();
            if (dbg_gnt) begin
                granted = 1'b1;
                dbg_exp_q.push_back(32'h00005678);
                checkOutput("forced grant stall", 32'(cpu_stall), 32'd1);
                checkOutput("forced grant mem_we", 32'(mem_we), 32'd0);
            end else begin
                blocked++;
                checkOutput("stream store no stall", 32'(cpu_stall), 32'd0);
                idx++;
            end
            toNext();
        end
        checkOutput("debug grant seen", 32'(granted), 32'd1);
        checkOutput("blocked cycles", 32'(blocked), 32'(WAIT_LIMIT));
        applyStimulus(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40 + 32'(4 * idx), 32'(idx),
                      1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput("dbg_valid after grant", 32'(dbg_valid), 32'd1);
        popDbg("dbg read 0x0C");
        checkOutput("cpu stalled in DBG_RD", 32'(cpu_stall), 32'd1);
        toNext();
        toSample();
        checkOutput("stream store resumes", 32'(mem_we), 32'hF);
        checkOutput("stream store no stall after", 32'(cpu_stall), 32'd0);
        toNext();
        clearInputs();
        toNext();

        $display("[TB] simultaneous load and debug read");
        applyStimulus(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0);
        cpu_exp_q.push_back(32'h00005678);
        toSample();
        checkOutput("tie cpu first gnt", 32'(dbg_gnt), 32'd0);
        checkOutput("tie cpu first stall", 32'(cpu_stall), 32'd1);
        toNext();
        toSample();
        checkOutput("tie CPU_RD gnt", 32'(dbg_gnt), 32'd0);
        popCpu("tie LW rdata");
        toNext();
        applyStimulus(1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0);
        toSample();
        checkOutput("tie debug granted", 32'(dbg_gnt), 32'd1);
        dbg_exp_q.push_back(32'h000000FF);
        toNext();
        clearInputs();
        toSample();
        checkOutput("tie dbg_valid", 32'(dbg_valid), 32'd1);
        popDbg("tie dbg read 0x04");
        toNext();
        toSample();
        checkOutput("dbg_valid pulse end", 32'(dbg_valid), 32'd0);
        checkOutput("dbg_rdata hold", dbg_rdata, 32'h000000FF);
        toNext();

        $display("[TB] reset during CPU_RD");
        applyStimulus(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        toSample();
        checkOutput("pre-reset load stall", 32'(cpu_stall), 32'd1);
        toNext();
        reset = 1'b1;
        clearInputs();
        toSample();
        checkOutput("reset in CPU_RD stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset in CPU_RD rdata", cpu_rdata, 32'h0);
        checkOutput("reset in CPU_RD mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset in CPU_RD dbg_rdata", dbg_rdata, 32'h0);
        toNext();
        reset = 1'b0;
        toNext();
        toSample();
        checkOutput("after reset rdata", cpu_rdata, 32'h0);
        toNext();
        doLoad("LW after reset", SIZE_WORD, 1'b0, 32'h30, 32'h00005678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
